// File: rtl/hsv_pixel_sequencer_pkg.sv
// Shared definitions for the HSV pixel sequencer and its threshold classifier.
package hsv_pixel_sequencer_pkg;

  // Sequencer states, one pixel per trip round the loop.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_GUARD = 3'd2,
    ST_WAIT  = 3'd3,
    ST_EMIT  = 3'd4
  } state_e;

  // Camera pixel layout: {x, r[4:0], g[4:0], b[4:0]}.
  localparam int unsigned PIX_W          = 16;
  localparam int unsigned PIX_B_LSB      = 0;
  localparam int unsigned PIX_G_LSB      = 5;
  localparam int unsigned PIX_R_LSB      = 10;
  localparam int unsigned PIX_CH_W       = 5;
  localparam int unsigned PIX_UNUSED_BIT = 15;

  // Default thresholds: a red window wrapping through hue 0.
  localparam logic [8:0] DEF_HUE_LO  = 9'd340;
  localparam logic [8:0] DEF_HUE_HI  = 9'd20;
  localparam logic [4:0] DEF_SAT_MIN = 5'd8;
  localparam logic [4:0] DEF_VAL_MIN = 5'd8;

  // Threshold set, latched once per frame.
  typedef struct packed {
    logic [8:0] hue_lo;
    logic [8:0] hue_hi;
    logic [4:0] sat_min;
    logic [4:0] val_min;
  } hsv_cfg_t;

  // Inclusive hue window; lo > hi means the window wraps through 0.
  function automatic logic hue_in_window(input logic [8:0] hue,
                                         input logic [8:0] lo,
                                         input logic [8:0] hi);
    if (lo <= hi) return (hue >= lo) && (hue <= hi);
    else          return (hue >= lo) || (hue <= hi);
  endfunction

endpackage

// File: rtl/hsv_threshold.sv
// Combinational HSV classifier: hue window plus saturation/value floors.
module hsv_threshold
  import hsv_pixel_sequencer_pkg::*;
(
  input  logic [8:0] hue_i,
  input  logic [4:0] sat_i,
  input  logic [4:0] val_i,
  input  logic       hue_invalid_i,
  input  hsv_cfg_t   cfg_i,
  output logic       hit_o
);

  // Ball pixel when chromatic, saturated and bright enough, and inside the window.
  // NOTE: hit_o is assigned on every path through always_comb, so no latch is inferred.
  always_comb begin
    hit_o = !hue_invalid_i
            && (sat_i >= cfg_i.sat_min)
            && (val_i >= cfg_i.val_min)
            && hue_in_window(hue_i, cfg_i.hue_lo, cfg_i.hue_hi);
  end

endmodule

// File: rtl/hsv_pixel_sequencer.sv
// Walks camera pixels one at a time through a shared rgb2hsv converter,
// classifies each result and emits a coordinate-tagged ball mask.
module hsv_pixel_sequencer
  import hsv_pixel_sequencer_pkg::*;
#(
  parameter int unsigned XW      = 10,
  parameter int unsigned YW      = 9,
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned CNTW    = 19
) (
  input  logic            clk,
  input  logic            res,
  input  logic            pix_valid,
  output logic            pix_ready,
  input  logic [15:0]     pix_data,
  input  logic            pix_sof,
  input  logic            pix_eol,
  input  logic [8:0]      cfg_hue_lo,
  input  logic [8:0]      cfg_hue_hi,
  input  logic [4:0]      cfg_sat_min,
  input  logic [4:0]      cfg_val_min,
  output logic            cv_read,
  output logic [15:0]     cv_data,
  input  logic            cv_done,
  input  logic [8:0]      cv_hue,
  input  logic [4:0]      cv_sat,
  input  logic [4:0]      cv_val,
  input  logic            cv_hue_invalid,
  output logic            mask_valid,
  output logic            mask,
  output logic [XW-1:0]   mask_x,
  output logic [YW-1:0]   mask_y,
  output logic [CNTW-1:0] frame_hits,
  output logic            timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam logic [PIX_W-1:0] PIX_KEEP = ~(PIX_W'(1) << PIX_UNUSED_BIT);

  state_e          state_q;
  hsv_cfg_t        cfg_q;
  logic            eol_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [CNTW-1:0] hit_q;
  logic [TW-1:0]   tcnt_q;
  logic            pix_ready_q, cv_read_q, mask_valid_q, mask_q, timeout_err_q;
  logic [15:0]     cv_data_q;
  logic [XW-1:0]   mask_x_q;
  logic [YW-1:0]   mask_y_q;
  logic [CNTW-1:0] frame_hits_q;
  logic            thr_hit;

  // The converter result is classified as it arrives; the decision is
  // registered on entry to EMIT instead of storing hue/sat/val.
  hsv_threshold u_threshold (
    .hue_i         (cv_hue),
    .sat_i         (cv_sat),
    .val_i         (cv_val),
    .hue_invalid_i (cv_hue_invalid),
    .cfg_i         (cfg_q),
    .hit_o         (thr_hit)
  );

  // Sequencer FSM with registered handshake, result and statistics outputs.
  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q       <= ST_IDLE;
      cfg_q         <= '0;
      eol_q         <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      hit_q         <= '0;
      tcnt_q        <= '0;
      pix_ready_q   <= 1'b0;
      cv_read_q     <= 1'b0;
      cv_data_q     <= '0;
      mask_valid_q  <= 1'b0;
      mask_q        <= 1'b0;
      mask_x_q      <= '0;
      mask_y_q      <= '0;
      frame_hits_q  <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cv_read_q    <= 1'b0;
      mask_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          pix_ready_q <= 1'b1;
          if (pix_ready_q && pix_valid) begin
            pix_ready_q <= 1'b0;
            cv_data_q   <= pix_data & PIX_KEEP;
            eol_q       <= pix_eol;
            cv_read_q   <= 1'b1;
            state_q     <= ST_ISSUE;
            if (pix_sof) begin
              x_q          <= '0;
              y_q          <= '0;
              cfg_q        <= '{hue_lo: cfg_hue_lo, hue_hi: cfg_hue_hi,
                                sat_min: cfg_sat_min, val_min: cfg_val_min};
              frame_hits_q <= hit_q;
              hit_q        <= '0;
            end
          end
        end
        ST_ISSUE: state_q <= ST_GUARD;
        ST_GUARD: begin
          // Converter may still show the previous done here; skip it.
          tcnt_q  <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cv_done) begin
            mask_q       <= thr_hit;
            mask_valid_q <= 1'b1;
            mask_x_q     <= x_q;
            mask_y_q     <= y_q;
            state_q      <= ST_EMIT;
          end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            mask_q        <= 1'b0;
            mask_valid_q  <= 1'b1;
            mask_x_q      <= x_q;
            mask_y_q      <= y_q;
            state_q       <= ST_EMIT;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        ST_EMIT: begin
          if (mask_q && (hit_q != '1)) hit_q <= hit_q + 1'b1;
          if (eol_q) begin
            x_q <= '0;
            y_q <= y_q + 1'b1;
          end else begin
            x_q <= x_q + 1'b1;
          end
          pix_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pix_ready   = pix_ready_q;
  assign cv_read     = cv_read_q;
  assign cv_data     = cv_data_q;
  assign mask_valid  = mask_valid_q;
  assign mask        = mask_q;
  assign mask_x      = mask_x_q;
  assign mask_y      = mask_y_q;
  assign frame_hits  = frame_hits_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/hsv_pixel_sequencer.md
Name: hsv_pixel_sequencer

Overview:
- Sequences a camera pixel stream through one shared rgb2hsv converter, one pixel at a time, using its read/done handshake.
- Classifies each converted pixel against programmable HSV thresholds and emits a 1-bit ball mask tagged with x/y coordinates.
- Keeps a per-frame hit count.
- Sits between the camera capture front end and the ball centroid/statistics logic.

Parameters:
- XW, 10, width of column coordinate.
- YW, 9, width of row coordinate.
- TIMEOUT, 32, cycles to wait for cv_done before aborting a pixel.
- CNTW, 19, width of per-frame hit counter.

Ports:
- clk  in  1  system clock
- res  in  1  reset; asynchronous, active-low (res=0 resets)
- pix_valid  in  1  input pixel present
- pix_ready  out  1  sequencer accepts pixel this cycle
- pix_data  in  16  pixel, {x,r[4:0],g[4:0],b[4:0]}; bit 15 ignored
- pix_sof  in  1  qualifies pixel as first of frame
- pix_eol  in  1  qualifies pixel as last of line
- cfg_hue_lo  in  9  hue window low bound, inclusive
- cfg_hue_hi  in  9  hue window high bound, inclusive
- cfg_sat_min  in  5  minimum saturation
- cfg_val_min  in  5  minimum value
- cv_read  out  1  one-cycle start pulse to converter
- cv_data  out  16  pixel to converter
- cv_done  in  1  converter result ready (level)
- cv_hue  in  9  converter hue
- cv_sat  in  5  converter saturation
- cv_val  in  5  converter value
- cv_hue_invalid  in  1  achromatic pixel
- mask_valid  out  1  one-cycle result strobe
- mask  out  1  1 = ball pixel
- mask_x  out  XW  column of result
- mask_y  out  YW  row of result
- frame_hits  out  CNTW  hit count of last completed frame
- timeout_err  out  1  sticky; set on converter timeout

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - x, y, hit counters 0.
  - Latched cfg registers 0.
- State machine IDLE -> ISSUE -> GUARD -> WAIT -> EMIT -> IDLE.
- IDLE:
  - pix_ready=1, asserted only in IDLE.
  - On pix_valid: latch pix_data into cv_data, latch sof/eol flags, go to ISSUE.
  - If sof: x=0, y=0, latch all cfg_* inputs. Config is stable for the whole frame.
- ISSUE:
  - cv_read=1 for exactly this cycle; go to GUARD.
- GUARD:
  - One cycle; cv_done ignored, because the converter drops a stale done one cycle after read.
  - Timeout counter cleared; go to WAIT.
- WAIT:
  - On cv_done=1: capture hue/sat/val/hue_invalid, go to EMIT.
  - Otherwise increment timeout counter. At TIMEOUT: set timeout_err, force mask=0, go to EMIT.
- EMIT:
  - mask_valid=1 for one cycle, with mask_x=x and mask_y=y.
  - mask = !hue_invalid & sat>=sat_min & val>=val_min & in_window.
  - in_window:
    - If hue_lo<=hue_hi: hue_lo<=hue<=hue_hi.
    - Else (window wraps through 0): hue>=hue_lo | hue<=hue_hi.
  - If mask=1: hit counter +1, saturating at all-ones.
  - Coordinate update:
    - If eol: x=0 and y=y+1; y wraps at 2^YW.
    - Else x=x+1; x wraps at 2^XW.
  - Return to IDLE.
- Frame boundary:
  - On the sof pixel, in the IDLE accept cycle: frame_hits <= hit counter, then hit counter cleared.
  - The sof pixel's own hit counts toward the new frame.
- Throughput: one pixel per (4 + converter latency) cycles, minimum 5 cycles per pixel.
- pix_valid while busy is back-pressured (pix_ready=0). Data must be held by the source.
- timeout_err clears only on reset.
- Asynchronous reset mid-conversion: the sequencer returns to IDLE immediately. A late cv_done after reset is ignored, because IDLE does not look at cv_done.
- Arithmetic: all comparisons unsigned; hue bounds 0..359; no rounding.

Decomposition:
- Shared package holds:
  - State encoding constants IDLE/ISSUE/GUARD/WAIT/EMIT.
  - Pixel field positions.
  - Default threshold constants.
- One natural sub-module, hsv_threshold: combinational window/saturation/value compare, reused later by the multi-colour classifier.

Test Plan:
- Handshake:
  - Stimulus: pixel 0x7C00 (pure red) with converter model done after 10 cycles; hue=0, sat=31, val=31; cfg 340..20, sat_min 8, val_min 8.
  - Response: exactly one cv_read pulse; mask_valid one cycle, mask=1, x=0, y=0.
- Wrap window:
  - Stimulus: hue=350, then 30, then 10, same cfg.
  - Response: masks 1, 0, 1.
- Achromatic:
  - Stimulus: pixel 0x4210, hue_invalid=1.
  - Response: mask=0; hit counter unchanged.
- Coordinates:
  - Stimulus: 3 pixels, third with eol, then 1 more.
  - Response: (0,0), (1,0), (2,0), (0,1).
- Frame count:
  - Stimulus: frame of 4 pixels with 3 hits, then a sof pixel.
  - Response: frame_hits=3 after the sof accept; new count starts.
- Timeout and reset:
  - Stimulus: converter never asserts done.
  - Response: mask_valid with mask=0 after TIMEOUT+3 cycles; timeout_err=1.
  - Then assert res=0 mid-WAIT: all outputs 0 asynchronously, pix_ready=1 after release.
